// File: rtl/z80_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z80_dma_pkg
// Description : Shared types and constants for the Z80 memory-fill/copy DMA
//               controller: transfer state encoding, mode encoding,
//               address/length/data widths and an address increment helper.
// Revision    : 1.0  initial release
// ============================================================================
package z80_dma_pkg;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 16;
    localparam int DATA_W = 8;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_REL  = 3'd4
    } dma_state_t;

    // Natural 16-bit rollover gives the FFFF -> 0000 wrap.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage : z80_dma_pkg
`default_nettype wire

// File: rtl/z80_dma_timeout.sv
`default_nettype none
// ============================================================================
// Module      : z80_dma_timeout
// Description : Loadable down-counter used to bound the wait for bus
//               acknowledge. Present only when Z80_DMA_TIMEOUT_EN is defined.
// Ports       : clk       - clock
//               reset_n   - asynchronous active-low reset
//               load_i    - reload counter with TIMEOUT_CYC-1
//               en_i      - count while waiting for acknowledge
//               expired_o - high while enabled and the count has run out
// Revision    : 1.0  initial release
// ============================================================================
module z80_dma_timeout #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    // Loaded with TIMEOUT_CYC-1 so that expiry is seen on the edge exactly
    // TIMEOUT_CYC cycles after the controller enters its request state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(TIMEOUT_CYC - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == '0);

endmodule : z80_dma_timeout
`default_nettype wire

// File: rtl/z80_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : z80_dma_ctrl
// Description : Memory fill/copy DMA controller for a tv80s system. Requests
//               the CPU bus with BUSRQ, then performs fill (1 cycle/byte) or
//               copy (read + write, 2 cycles/byte) and releases the bus.
// Config      : Z80_DMA_TIMEOUT_EN - when defined, abort with an err pulse if
//               BUSAK is not seen within TIMEOUT_CYC cycles of requesting.
// Ports       : clk, reset_n            - clock, async active-low reset
//               start, mode             - transfer request, 0 fill / 1 copy
//               src_addr, dst_addr, len - operands, latched on accepted start
//               fill_val                - fill byte
//               busy, done, err         - status (done/err one-cycle pulses)
//               cpu_busrq_n/cpu_busak_n - CPU bus request / acknowledge
//               bus_own                 - controller owns the memory bus
//               mem_a, mem_do, mem_di   - memory address / write / read data
//               mem_mreq_n/rd_n/wr_n    - memory strobes, active low
// Revision    : 1.0  initial release
// ============================================================================
module z80_dma_ctrl
    import z80_dma_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_busrq_n,
    input  logic              cpu_busak_n,
    output logic              bus_own,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_do,
    input  logic [DATA_W-1:0] mem_di,
    output logic              mem_mreq_n,
    output logic              mem_rd_n,
    output logic              mem_wr_n
);

    dma_state_t        state_q;
    logic [ADDR_W-1:0] src_q, dst_q, mem_a_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] fill_q, mem_do_q;
    logic              mode_q, busy_q, done_q, err_q, busrq_n_q, bus_own_q;
    logic              mreq_n_q, rd_n_q, wr_n_q;

    // Post-byte pointer/count values, used when a write completes.
    logic [ADDR_W-1:0] src_d, dst_d;
    logic [LEN_W-1:0]  cnt_d;

    assign src_d = addr_inc(src_q);
    assign dst_d = addr_inc(dst_q);
    assign cnt_d = cnt_q - LEN_W'(1);

    logic tmo_expired;

`ifdef Z80_DMA_TIMEOUT_EN
    logic tmo_load;
    logic tmo_en;

    assign tmo_load = (state_q == ST_IDLE) && start && (len != '0);
    assign tmo_en   = (state_q == ST_REQ);

    z80_dma_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (tmo_load),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );
`else
    // REQ waits forever; TIMEOUT_CYC is only referenced so the parameter
    // stays part of the interface in both builds.
    assign tmo_expired = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= MODE_FILL;
            fill_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busrq_n_q <= 1'b1;
            bus_own_q <= 1'b0;
            mem_a_q   <= '0;
            mem_do_q  <= '0;
            mreq_n_q  <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            src_q     <= src_addr;
                            dst_q     <= dst_addr;
                            cnt_q     <= len;
                            mode_q    <= mode;
                            fill_q    <= fill_val;
                            busy_q    <= 1'b1;
                            busrq_n_q <= 1'b0;
                            state_q   <= ST_REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (!cpu_busak_n) begin
                        bus_own_q <= 1'b1;
                        mreq_n_q  <= 1'b0;
                        if (mode_q == MODE_COPY) begin
                            mem_a_q <= src_q;
                            rd_n_q  <= 1'b0;
                            state_q <= ST_RD;
                        end else begin
                            mem_a_q  <= dst_q;
                            mem_do_q <= fill_q;
                            wr_n_q   <= 1'b0;
                            state_q  <= ST_WR;
                        end
                    end else if (tmo_expired) begin
                        busrq_n_q <= 1'b1;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    // The negedge-registered memory has mem_di valid by the
                    // end of the read cycle, so it is captured straight into
                    // the write data register.
                    rd_n_q   <= 1'b1;
                    wr_n_q   <= 1'b0;
                    mem_a_q  <= dst_q;
                    mem_do_q <= mem_di;
                    state_q  <= ST_WR;
                end
                ST_WR: begin
                    src_q  <= src_d;
                    dst_q  <= dst_d;
                    cnt_q  <= cnt_d;
                    wr_n_q <= 1'b1;
                    if (cnt_d != '0) begin
                        if (mode_q == MODE_COPY) begin
                            mem_a_q <= src_d;
                            rd_n_q  <= 1'b0;
                            state_q <= ST_RD;
                        end else begin
                            mem_a_q  <= dst_d;
                            mem_do_q <= fill_q;
                            wr_n_q   <= 1'b0;
                            state_q  <= ST_WR;
                        end
                    end else begin
                        bus_own_q <= 1'b0;
                        mreq_n_q  <= 1'b1;
                        busrq_n_q <= 1'b1;
                        state_q   <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (cpu_busak_n) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cpu_busrq_n = busrq_n_q;
    assign bus_own     = bus_own_q;
    assign mem_a       = mem_a_q;
    assign mem_do      = mem_do_q;
    assign mem_mreq_n  = mreq_n_q;
    assign mem_rd_n    = rd_n_q;
    assign mem_wr_n    = wr_n_q;

endmodule : z80_dma_ctrl
`default_nettype wire

// File: tb/tb_z80_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80_dma_ctrl
// Description : Self-checking bench for z80_dma_ctrl. A negedge-registered
//               memory model and a BUSAK responder surround the DUT; expected
//               writes are queued per scenario and popped as writes appear.
//               Timeout scenario follows Z80_DMA_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_z80_dma_ctrl;

    localparam int TMO = 16;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [7:0]  fill_val = '0;
    logic        busy, done, err, cpu_busrq_n, bus_own;
    logic        cpu_busak_n = 1'b1;
    logic [15:0] mem_a;
    logic [7:0]  mem_do;
    logic [7:0]  mem_di = '0;
    logic        mem_mreq_n, mem_rd_n, mem_wr_n;

    logic [7:0]  mem [0:65535];
    wr_t         exp_q [$];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int own_cnt = 0;
    int done_cnt = 0;
    bit ack_en = 1'b1;
    bit ack_glitch = 1'b0;
    int ack_cnt = 0;

    z80_dma_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .fill_val    (fill_val),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cpu_busrq_n (cpu_busrq_n),
        .cpu_busak_n (cpu_busak_n),
        .bus_own     (bus_own),
        .mem_a       (mem_a),
        .mem_do      (mem_do),
        .mem_di      (mem_di),
        .mem_mreq_n  (mem_mreq_n),
        .mem_rd_n    (mem_rd_n),
        .mem_wr_n    (mem_wr_n)
    );

    always #5 clk = ~clk;

    // BUSAK responder: acknowledge two cycles after BUSRQ, optional one-cycle
    // deassertion mid-transfer, release as soon as BUSRQ is withdrawn.
    initial forever begin
        @(posedge clk);
        #1;
        if (ack_en && !cpu_busrq_n) begin
            ack_cnt++;
            cpu_busak_n = !((ack_cnt >= 2) && !(ack_glitch && ack_cnt == 4));
        end else begin
            ack_cnt = 0;
            cpu_busak_n = 1'b1;
        end
    end

    // Memory model and write scoreboard.
    initial forever begin
        wr_t e;
        @(negedge clk);
        checks++;
        if ((!mem_rd_n && !mem_wr_n) ||
            (!bus_own && (!mem_mreq_n || !mem_rd_n || !mem_wr_n))) begin
            errors++;
            $display("FAIL strobe_rule: own=%b mreq_n=%b rd_n=%b wr_n=%b, required strobes high without ownership and never rd+wr",
                     bus_own, mem_mreq_n, mem_rd_n, mem_wr_n);
        end
        if (!mem_mreq_n && !mem_rd_n) begin
            rd_cnt++;
            mem_di = mem[mem_a];
        end
        if (!mem_mreq_n && !mem_wr_n) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_scoreboard: got write addr=%h data=%h, expected no write", mem_a, mem_do);
            end else begin
                e = exp_q.pop_front();
                if (mem_a !== e.a || mem_do !== e.d) begin
                    errors++;
                    $display("FAIL write_scoreboard: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_a, mem_do, e.a, e.d);
                end
            end
            mem[mem_a] = mem_do;
        end
        if (bus_own) own_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic [7:0] f);
        @(posedge clk);
        #1;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; own_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != 0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)         begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (cpu_busrq_n !== 1'b1) begin errors++; $display("FAIL rst_busrq: got %b want 1", cpu_busrq_n); end
        checks++; if (bus_own !== 1'b0)     begin errors++; $display("FAIL rst_own: got %b want 0", bus_own); end
        checks++; if ({mem_mreq_n, mem_rd_n, mem_wr_n} !== 3'b111)
            begin errors++; $display("FAIL rst_strobes: got %b want 111", {mem_mreq_n, mem_rd_n, mem_wr_n}); end
        checks++; if (mem_a !== 16'h0000)   begin errors++; $display("FAIL rst_mem_a: got %h want 0000", mem_a); end
        checks++; if (mem_do !== 8'h00)     begin errors++; $display("FAIL rst_mem_do: got %h want 00", mem_do); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fill();
        bit seen;
        mem[16'h4004] = 8'h3C;
        for (int i = 0; i < 4; i++) exp_q.push_back('{a: 16'(16'h4000 + i), d: 8'hA5});
        clear_counts();
        do_start(1'b0, 16'h0000, 16'h4000, 16'd4, 8'hA5);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || cpu_busrq_n !== 1'b0)
            begin errors++; $display("FAIL fill_accept: busy=%b busrq_n=%b want 1/0", busy, cpu_busrq_n); end
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL fill_done_timeout: no done within 200 cycles"); end
        checks++; if (busy !== 1'b0 || cpu_busrq_n !== 1'b1)
            begin errors++; $display("FAIL fill_release: busy=%b busrq_n=%b want 0/1", busy, cpu_busrq_n); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (done_cnt != 1)  begin errors++; $display("FAIL fill_done_count: got %0d want 1", done_cnt); end
        checks++; if (own_cnt != 4)   begin errors++; $display("FAIL fill_cycles: got %0d want 4", own_cnt); end
        checks++; if (rd_cnt != 0)    begin errors++; $display("FAIL fill_reads: got %0d want 0", rd_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fill_missing: %0d writes left want 0", exp_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16'(16'h4000 + i)] !== 8'hA5)
                begin errors++; $display("FAIL fill_mem[%0d]: got %h want a5", i, mem[16'(16'h4000 + i)]); end
        end
        checks++; if (mem[16'h4004] !== 8'h3C) begin errors++; $display("FAIL fill_mem_beyond: got %h want 3c", mem[16'h4004]); end
    endtask

    task automatic test_copy();
        bit seen;
        logic [7:0] pat [3];
        pat[0] = 8'hCB; pat[1] = 8'h91; pat[2] = 8'h5E;
        for (int i = 0; i < 3; i++) begin
            mem[16'(i)] = pat[i];
            exp_q.push_back('{a: 16'(16'h97E0 + i), d: pat[i]});
        end
        clear_counts();
        do_start(1'b1, 16'h0000, 16'h97E0, 16'd3, 8'hEE);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL copy_done_timeout: no done within 200 cycles"); end
        checks++; if (own_cnt != 6) begin errors++; $display("FAIL copy_cycles: got %0d want 6", own_cnt); end
        checks++; if (rd_cnt != 3 || wr_cnt != 3)
            begin errors++; $display("FAIL copy_strobes: reads=%0d writes=%0d want 3/3", rd_cnt, wr_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL copy_missing: %0d writes left want 0", exp_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[16'(16'h97E0 + i)] !== pat[i])
                begin errors++; $display("FAIL copy_mem[%0d]: got %h want %h", i, mem[16'(16'h97E0 + i)], pat[i]); end
        end
    endtask

    task automatic test_wrap();
        bit seen;
        logic [15:0] a;
        ack_glitch = 1'b1;
        a = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{a: a, d: 8'h11});
            a = a + 16'd1;
        end
        clear_counts();
        do_start(1'b0, 16'h0000, 16'hFFFE, 16'd4, 8'h11);
        wait_done(seen);
        ack_glitch = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL wrap_done_timeout: no done within 200 cycles"); end
        checks++; if (own_cnt != 4) begin errors++; $display("FAIL wrap_cycles: got %0d want 4", own_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err); end
        checks++;
        if (mem[16'hFFFE] !== 8'h11 || mem[16'hFFFF] !== 8'h11 || mem[16'h0000] !== 8'h11 || mem[16'h0001] !== 8'h11)
            begin errors++; $display("FAIL wrap_mem: got %h %h %h %h want 11 11 11 11",
                                     mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing: %0d writes left want 0", exp_q.size()); end
    endtask

    task automatic test_len0();
        bit busrq_seen;
        clear_counts();
        do_start(1'b0, 16'h0000, 16'h2000, 16'd0, 8'h99);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy); end
        busrq_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_busrq_n !== 1'b1) busrq_seen = 1'b1;
        end
        #1;
        checks++; if (busrq_seen) begin errors++; $display("FAIL len0_busrq: busrq_n went low, want stays 1"); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL len0_done_count: got %0d want 1", done_cnt); end
        checks++; if (wr_cnt != 0 || rd_cnt != 0)
            begin errors++; $display("FAIL len0_strobes: reads=%0d writes=%0d want 0/0", rd_cnt, wr_cnt); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        for (int i = 0; i < 3; i++) exp_q.push_back('{a: 16'(16'h6000 + i), d: 8'h5A});
        clear_counts();
        do_start(1'b0, 16'h0000, 16'h6000, 16'd3, 8'h5A);
        // A second request while busy must be ignored.
        do_start(1'b1, 16'h1234, 16'h7000, 16'd5, 8'h00);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL b2b_first_timeout: no done within 200 cycles"); end
        checks++; if (own_cnt != 3) begin errors++; $display("FAIL b2b_ignore_start: bus cycles %0d want 3", own_cnt); end
        exp_q.push_back('{a: 16'h6100, d: 8'h5A});
        exp_q.push_back('{a: 16'h6101, d: 8'h5A});
        clear_counts();
        do_start(1'b1, 16'h6000, 16'h6100, 16'd2, 8'h00);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL b2b_second_timeout: no done within 200 cycles"); end
        checks++; if (own_cnt != 4 || rd_cnt != 2)
            begin errors++; $display("FAIL b2b_copy_cycles: own=%0d reads=%0d want 4/2", own_cnt, rd_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: %0d writes left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit reached;
        for (int i = 0; i < 8; i++) mem[16'(16'h5000 + i)] = 8'h00;
        exp_q.push_back('{a: 16'h5000, d: 8'h77});
        exp_q.push_back('{a: 16'h5001, d: 8'h77});
        clear_counts();
        do_start(1'b0, 16'h0000, 16'h5000, 16'd8, 8'h77);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!reached) begin errors++; $display("FAIL rstmid_two_writes: writes %0d want 2", wr_cnt); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_busrq_n !== 1'b1 || bus_own !== 1'b0 ||
            {mem_mreq_n, mem_rd_n, mem_wr_n} !== 3'b111 || mem_a !== 16'h0000 || mem_do !== 8'h00)
            begin errors++; $display("FAIL rstmid_outputs: busy=%b done=%b err=%b busrq_n=%b own=%b strobes=%b a=%h do=%h want 0 0 0 1 0 111 0000 00",
                                     busy, done, err, cpu_busrq_n, bus_own, {mem_mreq_n, mem_rd_n, mem_wr_n}, mem_a, mem_do); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
        checks++; if (wr_cnt != 2) begin errors++; $display("FAIL rstmid_writes: got %0d want 2", wr_cnt); end
        checks++;
        if (mem[16'h5000] !== 8'h77 || mem[16'h5001] !== 8'h77 || mem[16'h5002] !== 8'h00)
            begin errors++; $display("FAIL rstmid_mem: got %h %h %h want 77 77 00",
                                     mem[16'h5000], mem[16'h5001], mem[16'h5002]); end
    endtask

    task automatic test_timeout();
        ack_en = 1'b0;
        clear_counts();
        do_start(1'b0, 16'h0000, 16'h3000, 16'd2, 8'h42);
`ifdef Z80_DMA_TIMEOUT_EN
        begin
            int k;
            k = -1;
            for (int i = 1; i <= TMO + 8; i++) begin
                @(negedge clk);
                if (err === 1'b1) begin
                    k = i - 1;
                    break;
                end
            end
            checks++; if (k != TMO) begin errors++; $display("FAIL tmo_latency: got %0d cycles want %0d", k, TMO); end
            checks++; if (busy !== 1'b0 || cpu_busrq_n !== 1'b1)
                begin errors++; $display("FAIL tmo_release: busy=%b busrq_n=%b want 0/1", busy, cpu_busrq_n); end
            @(negedge clk);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: err=%b want 0", err); end
        end
`else
        begin
            bit err_seen;
            err_seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (err !== 1'b0) err_seen = 1'b1;
            end
            checks++; if (err_seen) begin errors++; $display("FAIL noto_err: err pulsed, want tied 0"); end
            checks++; if (busy !== 1'b1 || cpu_busrq_n !== 1'b0 || bus_own !== 1'b0)
                begin errors++; $display("FAIL noto_wait: busy=%b busrq_n=%b own=%b want 1/0/0", busy, cpu_busrq_n, bus_own); end
            reset_n = 1'b0;
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
        end
`endif
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wr_cnt != 0) begin errors++; $display("FAIL tmo_no_writes: got %0d want 0", wr_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_z80_dma_ctrl
`default_nettype wire

// File: doc/z80_dma_ctrl.md
Z80_DMA_CTRL -- requirements
Module: z80_dma_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 256: cycles allowed between BUSRQ assertion and BUSAK before abort (used only under Z80_DMA_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle transfer request; sampled only in IDLE.
REQ-005 mode  in  1  0 = fill (write fill_val), 1 = copy (src -> dst).
REQ-006 src_addr  in  16  copy source start address; latched on accepted start.
REQ-007 dst_addr  in  16  destination start address; latched on accepted start.
REQ-008 len  in  16  byte count; latched on accepted start.
REQ-009 fill_val  in  8  fill byte; latched on accepted start.
REQ-010 busy  out  1  high from accepted start until done/err pulse.
REQ-011 done  out  1  one-cycle pulse on successful completion.
REQ-012 err  out  1  one-cycle pulse on timeout abort.
REQ-013 cpu_busrq_n  out  1  bus request to tv80s, active low.
REQ-014 cpu_busak_n  in  1  bus acknowledge from tv80s, active low.
REQ-015 bus_own  out  1  high while controller drives memory; selects controller over CPU in bus mux.
REQ-016 mem_a  out  16  memory address.
REQ-017 mem_do  out  8  write data.
REQ-018 mem_di  in  8  read data, valid the cycle after mem_rd_n low (negedge-registered memory).
REQ-019 mem_mreq_n, mem_rd_n, mem_wr_n  out  1 each  memory strobes, active low.

Function
REQ-020 States SHALL be IDLE, REQ, RD, WR, REL.
REQ-021 IDLE: start=1 with len!=0 latches operands, sets busy, drives cpu_busrq_n=0, goes to REQ; start with len=0 pulses done next cycle, no bus request.
REQ-022 start while busy SHALL be ignored.
REQ-023 REQ: on cpu_busak_n=0 sampled, set bus_own=1, go to RD (copy) or WR (fill).
REQ-024 RD: mem_a=src, mreq_n=0, rd_n=0 for one cycle, then WR.
REQ-025 WR: mem_a=dst, mem_do=captured mem_di (copy) or fill_val (fill), mreq_n=0, wr_n=0 for one cycle; dst+1, src+1, count-1.
REQ-026 After WR with count>0: next byte (RD or WR); count=0: REL.
REQ-027 Throughput: fill 1 cycle/byte, copy 2 cycles/byte after BUSAK.
REQ-028 Addresses SHALL wrap 16'hFFFF -> 16'h0000 without error.
REQ-029 REL: bus_own=0, strobes high, cpu_busrq_n=1; when cpu_busak_n=1 sampled, pulse done, clear busy, go IDLE.
REQ-030 Strobes SHALL be high whenever bus_own=0; never rd_n and wr_n low together.
REQ-031 cpu_busak_n deasserting mid-transfer SHALL be ignored (CPU cannot retake bus while busrq_n low).

Reset
REQ-032 reset_n=0 forces IDLE at once: busy=0, done=0, err=0, cpu_busrq_n=1, bus_own=0, mem strobes=1, mem_a=0, mem_do=0.
REQ-033 Reset mid-transfer abandons remaining bytes; no done pulse; bytes already written remain.

Configuration
REQ-034 Macro Z80_DMA_TIMEOUT_EN defined: in REQ, if BUSAK absent TIMEOUT_CYC cycles, release busrq_n, pulse err, clear busy, go IDLE.
REQ-035 Macro undefined: REQ waits indefinitely; err tied 0.

Structure
REQ-036 Package z80_dma_pkg SHALL hold state enum, mode constants (MODE_FILL, MODE_COPY), address/length widths.
REQ-037 One sub-module z80_dma_timeout (loadable down-counter, expiry flag), instantiated only under Z80_DMA_TIMEOUT_EN.

Verification
REQ-038 Fill: dst=16'h4000, len=4, fill_val=8'hA5, busak 2 cycles after busrq -> mem[4000..4003]=A5, mem[4004] unchanged, done once, busrq_n=1 after.
REQ-039 Copy: src=16'h0000 preloaded CB 91 5E, dst=16'h97E0, len=3 -> mem[97E0..97E2]=CB 91 5E, 6 write/read cycles after BUSAK.
REQ-040 Wrap: fill dst=16'hFFFE, len=4, val=8'h11 -> mem[FFFE,FFFF,0000,0001]=11.
REQ-041 len=0 start -> done pulse next cycle, cpu_busrq_n stays 1, no strobes.
REQ-042 Reset asserted after 2 of 8 fill bytes -> all outputs at reset values immediately, 2 bytes written, no done.
REQ-043 With Z80_DMA_TIMEOUT_EN, busak_n held 1 -> err pulse exactly TIMEOUT_CYC cycles after REQ entry, busrq_n=1, busy=0.
